// File: rtl/imem_loader_if.sv
// Load-stream and IMEM write bus of the instruction-memory loader.
// The master side feeds bytes and start; the slave side is the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: LEN_LO, LEN_HI, then N little-endian words; holds the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

    state_t            state_q;
    logic [15:0]       len_q;
    logic [16:0]       wcnt_q;
    logic [1:0]        bcnt_q;
    logic [23:0]       shift_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic        in_ready_d;
    logic        xfer_d;
    logic [16:0] len_d;
    logic [31:0] word_d;
    logic        last_word_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready_d = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign in_ready_d = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
`endif
    assign xfer_d      = bus.in_valid && in_ready_d;
    assign len_d       = {1'b0, bus.in_data, len_q[7:0]};
    assign word_d      = {bus.in_data, shift_q};
    assign last_word_d = (wcnt_q + 17'd1) == {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_q <= S_LEN0;
                        wcnt_q  <= '0;
                        bcnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (xfer_d) begin
                        len_q[7:0] <= bus.in_data;
                        state_q    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer_d) begin
                        len_q[15:8] <= bus.in_data;
                        wcnt_q      <= '0;
                        if (len_d == 17'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q <= S_CSUM;
`else
                            state_q <= S_DONE;
`endif
                        end else if (len_d > CAP) begin
                            state_q <= S_ERR;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.in_data;
`endif
                        if (bcnt_q == 2'd3) begin
                            // Address/data registers only move on the write edge so they stay stable otherwise.
                            we_q    <= 1'b1;
                            wdata_q <= word_d;
                            addr_q  <= wcnt_q[ADDR_W-1:0];
                            wcnt_q  <= wcnt_q + 17'd1;
                            bcnt_q  <= 2'd0;
                            if (last_word_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q <= S_CSUM;
`else
                                state_q <= S_DONE;
`endif
                            end
                        end else begin
                            shift_q[{bcnt_q, 3'b000} +: 8] <= bus.in_data;
                            bcnt_q <= bcnt_q + 2'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer_d) begin
                        state_q <= (bus.in_data == csum_q) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_d;
    assign bus.busy       = in_ready_d;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_rst    = (state_q != S_DONE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the IMEM word-address width; capacity is 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a load frame when sampled in IDLE, DONE or ERR.
REQ-005 in_valid  input  1  byte on in_data is valid.
REQ-006 in_data  input  8  load-stream byte.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 imem_we  output  1  IMEM write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  IMEM word address.
REQ-010 imem_wdata  output  32  IMEM write word.
REQ-011 cpu_rst  output  1  active-high reset held on riscv_cpu while loading.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  last frame loaded successfully; level, held until next start.
REQ-014 err  output  1  last frame aborted; level, held until next start.

Function
REQ-015 A byte SHALL transfer only on a cycle where in_valid and in_ready are both 1.
REQ-016 Frame format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each, LSB first.
REQ-017 FSM states SHALL be IDLE, LEN0, LEN1, DATA, DONE, ERR; start moves IDLE/DONE/ERR to LEN0; LEN0->LEN1 and LEN1->DATA each on one transfer.
REQ-018 in_ready SHALL be 1 exactly in LEN0, LEN1 and DATA; busy SHALL equal in_ready.
REQ-019 On LEN1 transfer: N=0 -> DONE; N>2^ADDR_W -> ERR; otherwise -> DATA with word address 0.
REQ-020 In DATA, the cycle after the 4th byte of a word transfers, imem_we SHALL be 1 for exactly one cycle with the assembled word on imem_wdata and the current address on imem_addr.
REQ-021 The word address SHALL increment after each write; after the Nth write the FSM SHALL enter DONE (no wrap for N=2^ADDR_W).
REQ-022 in_valid gaps SHALL stall assembly without losing partial bytes.
REQ-023 cpu_rst SHALL be 1 in every state except DONE; it SHALL deassert the cycle DONE is entered and reassert the cycle after start is sampled in DONE.
REQ-024 start sampled while busy SHALL be ignored.
REQ-025 imem_addr and imem_wdata SHALL be stable while imem_we is 0.

Reset
REQ-026 With rst=0 at a clock edge: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0; partial word and count cleared.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no further imem_we pulses; words already written are not rolled back.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: after the last data byte one checksum byte SHALL be expected, equal to the XOR of all data bytes (0x00 for N=0); match -> DONE, mismatch -> ERR, both on the checksum transfer.
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN undefined: no checksum byte; DONE is entered directly after the Nth write as in REQ-021.

Verification
REQ-030 Load N=10 with words 0x040300b7,0x20108093,0x08070137,0x60510113,0x00400193,0x2020850b,0xfff18193,0xfe019ce3,0x00a02023,0x0180066f -> 10 writes at addr 0..9 with those values, done=1, cpu_rst=0; the CPU then runs and DMEM[0]=280.
REQ-031 Same frame with in_valid deasserted for 3 cycles between every byte -> identical write sequence, no duplicated or dropped writes.
REQ-032 N=0 -> done=1 one cycle after LEN1, zero writes; N=0x0101 with ADDR_W=8 -> err=1, zero writes, cpu_rst=1.
REQ-033 rst=0 after 2 of 10 words -> exactly 2 writes, state IDLE, cpu_rst=1; a subsequent start plus full frame completes normally.
REQ-034 With IMEM_LOADER_CHECKSUM_EN: N=1 word 0x11223344 with checksum 0x44 -> done=1; same frame with checksum 0x45 -> err=1, the single write still occurred.
